// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and data-phase state type shared by the ahb_s2 responder and its bench.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [2:0] {
        BYTE       = 3'b000,
        HALFWORD   = 3'b001,
        WORD       = 3'b010,
        DOUBLEWORD = 3'b011,
        FOURWORD   = 3'b100,
        EIGHTWORD  = 3'b101
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        DP_IDLE,
        DP_WRITE,
        DP_READ,
        DP_ERR1,
        DP_ERR2
    } dp_state_t;

    // Low-address bits that must be zero for a transfer of 2**s bytes.
    function automatic logic [7:0] size_mask(input logic [2:0] s);
        return (8'd1 << s) - 8'd1;
    endfunction

endpackage

// File: rtl/ahb_s2_wfifo.sv
// ahb_s2_wfifo: synchronous write FIFO with registered occupancy and full flag.
module ahb_s2_wfifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_full;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_cnt_nxt;

    assign w_push    = i_push & ~r_full;
    assign w_pop     = i_pop & (r_cnt != '0);
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CW'(DEPTH));
        end
    end

    assign o_dout  = r_mem[r_rp];
    assign o_full  = r_full;
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

endmodule

// File: rtl/ahb_s2.sv
// ahb_s2: AHB-Lite write responder queueing {addr,size,data,strb} into a write FIFO.
// Optional burst protocol checker with proto_err output: define AHB_S2_PROTOCOL_CHECK_EN.
module ahb_s2
    import ahb_pkg::*;
#(
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          HSEL,
    input  logic [AHB_ADDRESS_WIDTH-1:0]  HADDR,
    input  logic                          HWRITE,
    input  logic [2:0]                    HSIZE,
    input  logic [2:0]                    HBURST,
    input  logic [1:0]                    HTRANS,
    input  logic [AHB_DATA_WIDTH-1:0]     HWDATA,
    input  logic                          HREADY,
    output logic                          HREADYOUT,
    output logic                          HRESP,
    output logic [AHB_DATA_WIDTH-1:0]     HRDATA,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [AHB_ADDRESS_WIDTH-1:0]  wr_addr,
    output logic [2:0]                    wr_size,
    output logic [AHB_DATA_WIDTH-1:0]     wr_data,
    output logic [AHB_DATA_WIDTH/8-1:0]   wr_strb
`ifdef AHB_S2_PROTOCOL_CHECK_EN
    ,
    output logic                          proto_err
`endif
);

    localparam int DW  = AHB_DATA_WIDTH;
    localparam int AW  = AHB_ADDRESS_WIDTH;
    localparam int NB  = DW / 8;
    localparam int LNB = $clog2(NB);
    localparam int EW  = AW + 3 + DW + NB;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    dp_state_t      r_state;
    dp_state_t      w_state_nxt;
    logic [AW-1:0]  r_addr;
    logic [2:0]     r_size;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic           w_hreadyout;
    logic           w_adv;
    logic           w_accept;
    logic           w_bad;
    logic           w_push;
    logic [LNB-1:0] w_lane;
    logic [NB-1:0]  w_strb;
    logic [DW-1:0]  w_wdata;
    logic [EW-1:0]  w_head;

    // A stalled write or the first error cycle holds the bus, so no address phase can be taken then.
    assign w_hreadyout = (r_state == DP_ERR1) ? 1'b0 : (r_state == DP_WRITE) ? ~w_full : 1'b1;
    assign w_adv       = HREADY & w_hreadyout;
    assign w_accept    = w_adv & HSEL & HTRANS[1];
    assign w_bad       = (HSIZE > 3'(LNB)) | (|(HADDR[7:0] & size_mask(HSIZE)));
    assign w_push      = (r_state == DP_WRITE) & w_adv;
    assign w_lane      = r_addr[LNB-1:0];

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == DP_ERR1) w_state_nxt = DP_ERR2;
        else if (w_adv) w_state_nxt = !w_accept ? DP_IDLE : w_bad ? DP_ERR1 : HWRITE ? DP_WRITE : DP_READ;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= DP_IDLE;
            r_addr  <= '0;
            r_size  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr <= HADDR;
                r_size <= HSIZE;
            end
        end
    end

    always_comb begin
        w_strb  = '0;
        w_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            w_strb[i]        = (i >= int'(w_lane)) && (i < int'(w_lane) + (1 << r_size));
            w_wdata[8*i +: 8] = w_strb[i] ? HWDATA[8*i +: 8] : 8'h00;
        end
    end

    ahb_s2_wfifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_push  (w_push),
        .i_pop   (wr_ready),
        .i_din   ({r_addr, r_size, w_wdata, w_strb}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign {wr_addr, wr_size, wr_data, wr_strb} = w_head;
    assign wr_valid  = ~w_empty;
    assign HREADYOUT = w_hreadyout;
    assign HRESP     = (r_state == DP_ERR1 || r_state == DP_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (r_state == DP_READ) ? DW'(w_count) : '0;

`ifdef AHB_S2_PROTOCOL_CHECK_EN
    logic          r_open;
    logic [AW-1:0] r_paddr;
    logic [2:0]    r_psize;
    logic [2:0]    r_pburst;
    logic          r_pwrite;
    logic          r_perr;
    logic          w_obs;
    logic          w_chg;
    logic          w_perr;

    assign w_obs = w_adv & HSEL;
    assign w_chg = (HSIZE != r_psize) | (HWRITE != r_pwrite) | (HBURST != r_pburst);

    always_comb begin
        w_perr = 1'b0;
        if (w_obs) w_perr = (HTRANS == SEQ) ? (~r_open | w_chg | (HADDR != r_paddr + (AW'(1) << HSIZE))) :
                            (HTRANS == BUSY) ? (~r_open | w_chg) : 1'b0;
    end

    // BUSY keeps the last beat address, so the next SEQ is checked against the beat before it.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_open   <= 1'b0;
            r_paddr  <= '0;
            r_psize  <= '0;
            r_pburst <= '0;
            r_pwrite <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_perr <= w_perr;
            if (w_obs && HTRANS == NONSEQ) begin
                r_open   <= (HBURST != SINGLE);
                r_paddr  <= HADDR;
                r_psize  <= HSIZE;
                r_pburst <= HBURST;
                r_pwrite <= HWRITE;
            end else if (w_obs && HTRANS == SEQ) r_paddr <= HADDR;
            else if (w_obs && HTRANS == IDLE) r_open <= 1'b0;
        end
    end

    assign proto_err = r_perr;
`else
    logic w_unused;
    assign w_unused = ^HBURST;
`endif

endmodule

// File: tb/tb_ahb_s2.sv
// tb_ahb_s2: directed AHB write/read/error/reset vectors with a queue-based write scoreboard.
module tb_ahb_s2;
    import ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = '0;
    logic [2:0]  HBURST = '0;
    logic [1:0]  HTRANS = '0;
    logic [63:0] HWDATA = '0;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] HRDATA;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [31:0] wr_addr;
    logic [2:0]  wr_size;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
`ifdef AHB_S2_PROTOCOL_CHECK_EN
    logic        proto_err;
`endif

    int total = 0;
    int bad = 0;
    int waits = 0;
    logic [106:0] exp_q [$];

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_s2 #(.AHB_DATA_WIDTH(64), .AHB_ADDRESS_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_size   (wr_size),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb)
`ifdef AHB_S2_PROTOCOL_CHECK_EN
        ,
        .proto_err (proto_err)
`endif
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [2:0] s, input logic [63:0] d, input logic [7:0] b);
        exp_q.push_back({a, s, d, b});
    endtask

    // Presents one address phase plus the previous beat's write data, returning after it is accepted.
    task automatic step(input logic [1:0] t, input logic [31:0] a, input logic [2:0] s,
                        input logic w, input logic [2:0] b, input logic [63:0] d);
        int n = 0;
        HSEL = 1'b1; HTRANS = t; HADDR = a; HSIZE = s; HWRITE = w; HBURST = b; HWDATA = d;
        @(negedge HCLK);
        while (!HREADY && n < 20) begin
            n++;
            waits++;
            @(negedge HCLK);
        end
        if (!HREADY) begin
            total++;
            bad++;
            $display("FAIL step_timeout: got HREADY=0 want 1 at addr %0h", a);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic do_err(input logic [31:0] a, input logic [2:0] s);
        step(NONSEQ, a, s, 1'b1, SINGLE, 64'h0);
        HTRANS = IDLE;
        @(negedge HCLK);
        chk("err1_hreadyout", HREADYOUT, 1'b0);
        chk("err1_hresp", HRESP, 1'b1);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("err2_hreadyout", HREADYOUT, 1'b1);
        chk("err2_hresp", HRESP, 1'b1);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("err_done_hresp", HRESP, 1'b0);
        chk("err_no_push", wr_valid, 1'b0);
        @(posedge HCLK); #1;
    endtask

    always @(negedge HCLK) begin
        if (!HRESET && wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got addr %0h data %0h want no entry", wr_addr, wr_data);
            end else begin
                chk("pop_entry", {wr_addr, wr_size, wr_data, wr_strb}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_hreadyout", HREADYOUT, 1'b1);
        chk("rst_hresp", HRESP, 1'b0);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_hrdata", HRDATA, 64'h0);
        @(posedge HCLK); #1;

        wr_ready = 1'b1;
        waits = 0;
        step(NONSEQ, 32'h0, 3'd2, 1'b1, INCR4, 64'h0);
        expect_wr(32'h0, 3'd2, 64'h0000_0000_0000_0001, 8'h0F);
        step(SEQ, 32'h4, 3'd2, 1'b1, INCR4, 64'hDEAD_BEEF_0000_0001);
        expect_wr(32'h4, 3'd2, 64'h0000_0002_0000_0000, 8'hF0);
        step(SEQ, 32'h8, 3'd2, 1'b1, INCR4, 64'h0000_0002_FFFF_FFFF);
        expect_wr(32'h8, 3'd2, 64'h0000_0000_0000_0003, 8'h0F);
        step(SEQ, 32'hC, 3'd2, 1'b1, INCR4, 64'h5555_5555_0000_0003);
        expect_wr(32'hC, 3'd2, 64'h0000_0004_0000_0000, 8'hF0);
        step(IDLE, 32'h0, 3'd2, 1'b1, INCR4, 64'h0000_0004_1234_5678);
        chk("burst_zero_wait", waits, 0);
        cyc(3);
        chk("burst_drained", wr_valid, 1'b0);
        chk("burst_all_popped", exp_q.size(), 0);

        wr_ready = 1'b0;
        step(NONSEQ, 32'h0, 3'd2, 1'b1, INCR4, 64'h0);
        expect_wr(32'h0, 3'd2, 64'h0000_0000_0000_0001, 8'h0F);
        step(SEQ, 32'h4, 3'd2, 1'b1, INCR4, 64'hDEAD_BEEF_0000_0001);
        expect_wr(32'h4, 3'd2, 64'h0000_0002_0000_0000, 8'hF0);
        step(SEQ, 32'h8, 3'd2, 1'b1, INCR4, 64'h0000_0002_FFFF_FFFF);
        expect_wr(32'h8, 3'd2, 64'h0000_0000_0000_0003, 8'h0F);
        step(SEQ, 32'hC, 3'd2, 1'b1, INCR4, 64'h5555_5555_0000_0003);
        expect_wr(32'hC, 3'd2, 64'h0000_0004_0000_0000, 8'hF0);
        step(NONSEQ, 32'h10, 3'd2, 1'b1, SINGLE, 64'h0000_0004_1234_5678);
        expect_wr(32'h10, 3'd2, 64'h0000_0000_BBBB_BBBB, 8'h0F);
        HTRANS = IDLE;
        HWDATA = 64'hAAAA_AAAA_BBBB_BBBB;
        @(negedge HCLK);
        chk("full_stall_1", HREADYOUT, 1'b0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("full_stall_2", HREADYOUT, 1'b0);
        @(posedge HCLK); #1;
        wr_ready = 1'b1;
        @(negedge HCLK);
        chk("full_pop_still_stalls", HREADYOUT, 1'b0);
        @(posedge HCLK); #1;
        wr_ready = 1'b0;
        @(negedge HCLK);
        chk("stall_released", HREADYOUT, 1'b1);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("fifo_refilled", wr_valid, 1'b1);
        @(posedge HCLK); #1;
        wr_ready = 1'b1;
        cyc(6);
        chk("stall_all_popped", exp_q.size(), 0);
        chk("stall_drained", wr_valid, 1'b0);

        do_err(32'h3, 3'd1);
        do_err(32'h0, 3'd4);

        wr_ready = 1'b0;
        step(NONSEQ, 32'h20, 3'd2, 1'b1, SINGLE, 64'h0);
        expect_wr(32'h20, 3'd2, 64'h0000_0000_CAFE_F00D, 8'h0F);
        step(NONSEQ, 32'h25, 3'd0, 1'b1, SINGLE, 64'h9999_9999_CAFE_F00D);
        expect_wr(32'h25, 3'd0, 64'h0000_3300_0000_0000, 8'h20);
        step(NONSEQ, 32'h0, 3'd2, 1'b0, SINGLE, 64'h1122_3344_5566_7788);
        HTRANS = IDLE;
        @(negedge HCLK);
        chk("read_hrdata", HRDATA, 64'h2);
        chk("read_hreadyout", HREADYOUT, 1'b1);
        chk("read_hresp", HRESP, 1'b0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("read_hrdata_after", HRDATA, 64'h0);
        @(posedge HCLK); #1;
        wr_ready = 1'b1;
        cyc(4);
        chk("read_all_popped", exp_q.size(), 0);

        wr_ready = 1'b1;
        step(NONSEQ, 32'h0, 3'd2, 1'b1, INCR4, 64'h0);
        expect_wr(32'h0, 3'd2, 64'h0000_0000_0000_0001, 8'h0F);
        step(SEQ, 32'h4, 3'd2, 1'b1, INCR4, 64'h0000_0000_0000_0001);
        expect_wr(32'h4, 3'd2, 64'h0000_0005_0000_0000, 8'hF0);
        step(BUSY, 32'h8, 3'd2, 1'b1, INCR4, 64'h0000_0005_0000_0000);
        step(SEQ, 32'h8, 3'd2, 1'b1, INCR4, 64'hFFFF_FFFF_FFFF_FFFF);
        wr_ready = 1'b0;
        step(SEQ, 32'hC, 3'd2, 1'b1, INCR4, 64'h0000_0000_0000_0007);
        @(negedge HCLK);
        chk("busy_no_push", exp_q.size(), 0);
        chk("pre_reset_valid", wr_valid, 1'b1);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        HTRANS = IDLE;
        HSEL = 1'b0;
        wr_ready = 1'b1;
        @(negedge HCLK);
        chk("midburst_rst_valid", wr_valid, 1'b0);
        chk("midburst_rst_hreadyout", HREADYOUT, 1'b1);
        chk("midburst_rst_hresp", HRESP, 1'b0);
        chk("midburst_rst_hrdata", HRDATA, 64'h0);
        @(posedge HCLK); #1;
        cyc(3);

`ifdef AHB_S2_PROTOCOL_CHECK_EN
        step(NONSEQ, 32'h0, 3'd2, 1'b1, INCR4, 64'h0);
        chk("proto_quiet_nonseq", proto_err, 1'b0);
        expect_wr(32'h0, 3'd2, 64'h0000_0000_0000_0001, 8'h0F);
        step(SEQ, 32'h4, 3'd2, 1'b1, INCR4, 64'h0000_0000_0000_0001);
        chk("proto_quiet_seq", proto_err, 1'b0);
        expect_wr(32'h4, 3'd2, 64'h0000_0009_0000_0000, 8'hF0);
        step(SEQ, 32'h10, 3'd2, 1'b1, INCR4, 64'h0000_0009_0000_0000);
        chk("proto_pulse", proto_err, 1'b1);
        expect_wr(32'h10, 3'd2, 64'h0000_0000_0000_000A, 8'h0F);
        step(IDLE, 32'h0, 3'd2, 1'b1, INCR4, 64'h0000_0000_0000_000A);
        chk("proto_pulse_end", proto_err, 1'b0);
        cyc(4);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
